// File: rtl/apb_wait_regfile.sv
// APB slave register file with a fixed number of access-phase wait states.
// Transfer fields are captured in the setup phase; writes commit when leaving READY.
module apb_wait_regfile #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [3:0] LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    err_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [BYTES-1:0]        strb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Misaligned or beyond the last word.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = a >> OFF;
    return ((a & ALIGN_MASK) != '0) || (32'(w) >= DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = a >> OFF;
    return w[IDX_W-1:0];
  endfunction

  assign PREADY  = (state == READY);
  assign PSLVERR = (state == READY) && err_q;
  assign PRDATA  = rdata_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          // PENABLE high here is a protocol violation and is simply not a setup phase.
          if (PSEL && !PENABLE) begin
            write_q <= PWRITE;
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            err_q   <= addr_err(PADDR);
            if (WAIT_STATES == 0) begin
              state <= READY;
              if (!PWRITE)
                rdata_q <= addr_err(PADDR) ? '0 : mem[word_idx(PADDR)];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == LAST) begin
            state <= READY;
            if (!write_q)
              rdata_q <= err_q ? '0 : mem[word_idx(addr_q)];
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        READY: begin
          state <= IDLE;
          cnt   <= 4'd0;
          if (write_q && !err_q) begin
            for (int b = 0; b < BYTES; b++)
              if (strb_q[b]) mem[word_idx(addr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_wait_regfile.sv
// Scoreboard bench for apb_wait_regfile: one DUT with two wait states, one with none.
module tb_apb_wait_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel = 1'b0, psel_z = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata, prdata_z;
  logic        pready, pready_z, pslverr, pslverr_z;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          waits;
  } txn_t;

  txn_t sbq[$];
  txn_t obq[$];
  logic [31:0] mm [32];
  logic [31:0] mz [32];

  always #5 clk = ~clk;

  apb_wait_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(2)) dut (
    .PCLK(clk), .PRESET(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr));

  apb_wait_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) dut_z (
    .PCLK(clk), .PRESET(rst), .PSEL(psel_z), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata_z), .PREADY(pready_z), .PSLVERR(pslverr_z));

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      mm[i] = '0;
      mz[i] = '0;
    end
  endtask

  // Drives one transfer; expected result pushed at setup, observed pushed at PREADY.
  task automatic xfer(input bit z, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit scr);
    txn_t e, o;
    int n, idx;
    e.rd = !wr;
    e.err = (a >= 8'd128) || (a[1:0] != 2'b00);
    e.waits = z ? 0 : 2;
    e.data = '0;
    idx = int'(a >> 2);
    if (!e.err) begin
      if (!wr) e.data = z ? mz[idx] : mm[idx];
      else
        for (int b = 0; b < 4; b++)
          if (s[b]) begin
            if (z) mz[idx][8*b +: 8] = d[8*b +: 8];
            else   mm[idx][8*b +: 8] = d[8*b +: 8];
          end
    end
    sbq.push_back(e);
    if (z) psel_z = 1'b1; else psel = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (!(z ? pready_z : pready) && n < 20) begin
      if (scr) begin
        paddr = 8'($urandom); pwdata = $urandom; pstrb = 4'($urandom); pwrite = ~pwrite;
      end
      @(posedge clk); #1;
      n++;
    end
    o.rd = e.rd;
    o.waits = (z ? pready_z : pready) ? n : -1;
    o.err = z ? pslverr_z : pslverr;
    o.data = z ? prdata_z : prdata;
    obq.push_back(o);
    @(posedge clk); #1;
    psel = 1'b0; psel_z = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    compared++;
    if ({pready, pslverr, prdata, pready_z, pslverr_z, prdata_z} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b/%b/%h expected 0/0/0", pready, pslverr, prdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_models();
  endtask

  task automatic test_basic();
    txn_t e, o;
    xfer(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, 0);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 0);
    xfer(0, 0, 8'h14, 32'h0, 4'h0, 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = obq.pop_front();
      compared++;
      if (o.waits !== e.waits) begin mismatched++; $display("FAIL basic_waits: got %0d expected %0d", o.waits, e.waits); end
      compared++;
      if (o.err !== e.err) begin mismatched++; $display("FAIL basic_slverr: got %b expected %b", o.err, e.err); end
      if (e.rd) begin
        compared++;
        if (o.data !== e.data) begin mismatched++; $display("FAIL basic_rdata: got %h expected %h", o.data, e.data); end
      end
    end
  endtask

  task automatic test_strobes();
    txn_t e, o;
    xfer(0, 1, 8'h10, 32'h11223344, 4'h5, 0);
    xfer(0, 0, 8'h10, 32'h0, 4'hF, 0);
    xfer(0, 1, 8'h10, 32'hFFFFFFFF, 4'h0, 0);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 0);
    xfer(0, 1, 8'h7C, 32'hA5A55A5A, 4'hA, 0);
    xfer(0, 0, 8'h7C, 32'h0, 4'h0, 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = obq.pop_front();
      compared++;
      if (o.waits !== e.waits) begin mismatched++; $display("FAIL strobe_waits: got %0d expected %0d", o.waits, e.waits); end
      compared++;
      if (o.err !== e.err) begin mismatched++; $display("FAIL strobe_slverr: got %b expected %b", o.err, e.err); end
      if (e.rd) begin
        compared++;
        if (o.data !== e.data) begin mismatched++; $display("FAIL strobe_rdata: got %h expected %h", o.data, e.data); end
      end
    end
  endtask

  task automatic test_errors();
    txn_t e, o;
    xfer(0, 0, 8'hFC, 32'h0, 4'hF, 0);
    xfer(0, 1, 8'h11, 32'h12345678, 4'hF, 0);
    xfer(0, 1, 8'h80, 32'h87654321, 4'hF, 0);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 0);
    xfer(0, 0, 8'h00, 32'h0, 4'h0, 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = obq.pop_front();
      compared++;
      if (o.waits !== e.waits) begin mismatched++; $display("FAIL err_waits: got %0d expected %0d", o.waits, e.waits); end
      compared++;
      if (o.err !== e.err) begin mismatched++; $display("FAIL err_slverr: got %b expected %b", o.err, e.err); end
      if (e.rd) begin
        compared++;
        if (o.data !== e.data) begin mismatched++; $display("FAIL err_rdata: got %h expected %h", o.data, e.data); end
      end
    end
  endtask

  task automatic test_ignore_changes();
    txn_t e, o;
    xfer(0, 1, 8'h20, 32'hCAFEF00D, 4'hF, 1);
    xfer(0, 0, 8'h24, 32'h0, 4'h0, 1);
    xfer(0, 0, 8'h20, 32'h0, 4'h0, 1);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = obq.pop_front();
      compared++;
      if (o.waits !== e.waits) begin mismatched++; $display("FAIL hold_waits: got %0d expected %0d", o.waits, e.waits); end
      compared++;
      if (o.err !== e.err) begin mismatched++; $display("FAIL hold_slverr: got %b expected %b", o.err, e.err); end
      if (e.rd) begin
        compared++;
        if (o.data !== e.data) begin mismatched++; $display("FAIL hold_rdata: got %h expected %h", o.data, e.data); end
      end
    end
  endtask

  task automatic test_zero_wait();
    txn_t e, o;
    xfer(1, 1, 8'h04, 32'h0BADF00D, 4'hF, 0);
    xfer(1, 0, 8'h04, 32'h0, 4'h0, 0);
    xfer(1, 1, 8'h04, 32'h55667788, 4'h3, 0);
    xfer(1, 0, 8'h04, 32'h0, 4'h0, 0);
    xfer(1, 0, 8'h06, 32'h0, 4'h0, 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = obq.pop_front();
      compared++;
      if (o.waits !== e.waits) begin mismatched++; $display("FAIL zw_waits: got %0d expected %0d", o.waits, e.waits); end
      compared++;
      if (o.err !== e.err) begin mismatched++; $display("FAIL zw_slverr: got %b expected %b", o.err, e.err); end
      if (e.rd) begin
        compared++;
        if (o.data !== e.data) begin mismatched++; $display("FAIL zw_rdata: got %h expected %h", o.data, e.data); end
      end
    end
  endtask

  task automatic test_abort();
    txn_t e, o;
    int seen;
    seen = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'hFEEDFACE; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    seen += int'(pready);
    @(posedge clk); #1;
    seen += int'(pready);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen += int'(pready);
    end
    compared++;
    if (seen !== 0) begin mismatched++; $display("FAIL abort_pready: got %0d ready cycles expected 0", seen); end
    xfer(0, 0, 8'h08, 32'h0, 4'h0, 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = obq.pop_front();
      compared++;
      if (o.waits !== e.waits) begin mismatched++; $display("FAIL abort_waits: got %0d expected %0d", o.waits, e.waits); end
      compared++;
      if (o.data !== e.data) begin mismatched++; $display("FAIL abort_rdata: got %h expected %h", o.data, e.data); end
    end
  endtask

  task automatic test_penable_in_idle();
    int seen;
    seen = 0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h13579BDF; pstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen += int'(pready);
    end
    psel = 1'b0; penable = 1'b0;
    compared++;
    if (seen !== 0) begin mismatched++; $display("FAIL idle_penable_pready: got %0d ready cycles expected 0", seen); end
  endtask

  task automatic test_reset_mid();
    txn_t e, o;
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h30; pwdata = 32'h99999999; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    #1;
    compared++;
    if ({pready, pslverr, prdata} !== '0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got %b/%b/%h expected 0/0/0", pready, pslverr, prdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    clear_models();
    xfer(0, 0, 8'h30, 32'h0, 4'h0, 0);
    xfer(0, 0, 8'h20, 32'h0, 4'h0, 0);
    xfer(0, 1, 8'h30, 32'h2468ACE0, 4'hF, 0);
    xfer(0, 0, 8'h30, 32'h0, 4'h0, 0);
    // The first entry is the pre-reset read of 0x10.
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = obq.pop_front();
      compared++;
      if (o.waits !== e.waits) begin mismatched++; $display("FAIL midreset_waits: got %0d expected %0d", o.waits, e.waits); end
      if (e.rd) begin
        compared++;
        if (o.data !== e.data) begin mismatched++; $display("FAIL midreset_rdata: got %h expected %h", o.data, e.data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobes();
    test_errors();
    test_ignore_changes();
    test_zero_wait();
    test_abort();
    test_penable_in_idle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
